cpu_mem_arbiter: RTL and testbench

Two-to-one arbiter that shares one sram-like memory port between the IF stage instruction-fetch requester and the EXE/MEM data requester. It sits between the pipeline stages and the single memory/bus bridge and allows at most one outstanding transaction. Grants are 2-way round-robin, with data winning ties after an instruction grant. Per-requester addr_ok/data_ok handshakes are routed so each stage sees only its own responses.

---
 rtl/cpu_mem_pkg.sv | 29 ++
 rtl/cpu_mem_arbiter_rr2_pick.sv | 29 ++
 rtl/cpu_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU-side memory arbitration logic.
//   state_e  : arbiter FSM states (IDLE, REQ, RESP)
//   owner_e  : which requester holds the memory port (OWN_INST, OWN_DATA)
//   SZ_*     : memory access size encodings on *_size ports
//   DEF_*_W  : default address/data widths
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage : cpu_mem_pkg

// File: rtl/cpu_mem_arbiter_rr2_pick.sv
// ---------------------------------------------------------------------------
// rr2_pick
// Two-way round-robin selector, purely combinational.
//   req_i[0] : instruction requester active
//   req_i[1] : data requester active
//   last     : owner granted most recently
//   grant    : chosen owner; a lone request always wins, a tie goes to the
//              requester that was not granted last time.
// With no request the output is OWN_INST and is ignored by the caller.
// ---------------------------------------------------------------------------
module rr2_pick
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last,
    output owner_e     grant
);

    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        grant = OWN_INST;
        if (req_i == 2'b10) begin
            grant = OWN_DATA;
        end else if (req_i == 2'b11) begin
            grant = (last == OWN_DATA) ? OWN_INST : OWN_DATA;
        end
    end

endmodule : rr2_pick

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares one sram-like memory port between the instruction-fetch requester
// and the data (load/store) requester, one outstanding transaction at a time.
//   clk, reset                  : clock, synchronous active-high reset
//   inst_req/inst_addr          : fetch request
//   inst_addr_ok/data_ok/rdata  : fetch handshake and read data
//   data_req/wr/size/addr/wstrb/wdata : load/store request
//   data_addr_ok/data_ok/rdata  : load/store handshake and read data
//   mem_req/wr/size/addr/wstrb/wdata  : request toward memory
//   mem_addr_ok/data_ok/rdata   : memory handshake and read data
// The mem_* request fields are zero whenever no request is being presented,
// and each requester only ever sees its own addr_ok/data_ok pulses.
// ---------------------------------------------------------------------------
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e r_state;
    owner_e r_owner;
    owner_e r_last;

    owner_e w_grant;
    logic   w_any_req;
    logic   w_in_req;
    logic   w_in_resp;

    assign w_any_req = inst_req | data_req;
    assign w_in_req  = (r_state == REQ);
    assign w_in_resp = (r_state == RESP);

    rr2_pick u_pick (
        .req_i ({data_req, inst_req}),
        .last  (r_last),
        .grant (w_grant)
    );

    // Owner and last are only updated on a fresh grant, so the owner stays
    // locked through REQ even if the other requester shows up meanwhile.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_state <= IDLE;
            r_owner <= OWN_INST;
            r_last  <= OWN_INST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_addr_ok) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_data_ok) begin
                        if (w_any_req) begin
                            r_owner <= w_grant;
                            r_last  <= w_grant;
                            r_state <= REQ;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // mem_req decodes registered state only: no path from *_req to mem_req.
    assign mem_req = w_in_req;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = '0;
        mem_wstrb = 4'd0;
        mem_wdata = '0;
        if (w_in_req) begin
            if (r_owner == OWN_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wstrb = data_wstrb;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = SZ_WORD;
                mem_addr  = inst_addr;
            end
        end
    end

    // Handshakes are qualified by state, so stray memory pulses are dropped.
    assign inst_addr_ok = w_in_req  & mem_addr_ok & (r_owner == OWN_INST);
    assign data_addr_ok = w_in_req  & mem_addr_ok & (r_owner == OWN_DATA);
    assign inst_data_ok = w_in_resp & mem_data_ok & (r_owner == OWN_INST);
    assign data_data_ok = w_in_resp & mem_data_ok & (r_owner == OWN_DATA);

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule : cpu_mem_arbiter

// File: tb/tb_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_arbiter
// Directed testbench for cpu_mem_arbiter. Inputs change 1 ns after the
// rising edge, outputs are sampled 2 ns later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_errors;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'h0;
        data_wstrb  = 4'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    // Leaves the bench in cycle 0 of the next test: reset released, FSM in IDLE.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_mem_req"},   64'(mem_req),      64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),     64'd0);
        check({tag, "_mem_wr"},    64'(mem_wr),       64'd0);
        check({tag, "_mem_wstrb"}, 64'(mem_wstrb),    64'd0);
        check({tag, "_i_aok"},     64'(inst_addr_ok), 64'd0);
        check({tag, "_d_aok"},     64'(data_addr_ok), 64'd0);
        check({tag, "_i_dok"},     64'(inst_data_ok), 64'd0);
        check({tag, "_d_dok"},     64'(data_data_ok), 64'd0);
    endtask

    logic exp_data_owner;

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ---- reset state, with stray memory handshakes driven throughout ----
        clear_inputs();
        reset       = 1'b1;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        data_addr   = 32'h55;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        step();
        step();
        #2;
        check_all_idle("rst");

        // ---- single fetch ----
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #2;
        check("f_c0_mem_req", 64'(mem_req), 64'd0);
        step();
        mem_addr_ok = 1'b1;
        #2;
        check("f_c1_mem_req",  64'(mem_req),      64'd1);
        check("f_c1_mem_addr", 64'(mem_addr),     64'hBFC0_0000);
        check("f_c1_mem_size", 64'(mem_size),     64'd2);
        check("f_c1_mem_wr",   64'(mem_wr),       64'd0);
        check("f_c1_i_aok",    64'(inst_addr_ok), 64'd1);
        check("f_c1_d_aok",    64'(data_addr_ok), 64'd0);
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #2;
        check("f_c2_mem_req", 64'(mem_req),      64'd0);
        check("f_c2_i_dok",   64'(inst_data_ok), 64'd0);
        step();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h3C1D_0000;
        #2;
        check("f_c3_i_dok",  64'(inst_data_ok), 64'd1);
        check("f_c3_irdata", 64'(inst_rdata),   64'h3C1D_0000);
        check("f_c3_d_dok",  64'(data_data_ok), 64'd0);
        step();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #2;
        check("f_c4_mem_req", 64'(mem_req), 64'd0);
        step();
        #2;
        check("f_c5_mem_req", 64'(mem_req), 64'd0);

        // ---- tie after reset: data first, then inst straight from RESP ----
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1000;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h0000_0200;
        step();
        mem_addr_ok = 1'b1;
        #2;
        check("t_c1_mem_addr", 64'(mem_addr),     64'h200);
        check("t_c1_d_aok",    64'(data_addr_ok), 64'd1);
        check("t_c1_i_aok",    64'(inst_addr_ok), 64'd0);
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #2;
        check("t_c2_mem_req", 64'(mem_req), 64'd0);
        step();
        mem_data_ok = 1'b1;
        #2;
        check("t_c3_d_dok", 64'(data_data_ok), 64'd1);
        check("t_c3_i_dok", 64'(inst_data_ok), 64'd0);
        step();
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        #2;
        check("t_c4_mem_req",  64'(mem_req),      64'd1);
        check("t_c4_mem_addr", 64'(mem_addr),     64'h1000);
        check("t_c4_i_aok",    64'(inst_addr_ok), 64'd1);
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #2;
        check("t_c5_i_dok", 64'(inst_data_ok), 64'd1);
        check("t_c5_d_dok", 64'(data_data_ok), 64'd0);

        // ---- sustained contention: D, I, D, I ... one grant per 2 cycles ----
        do_reset();
        inst_req    = 1'b1;
        inst_addr   = 32'h0000_1000;
        data_req    = 1'b1;
        data_addr   = 32'h0000_0200;
        data_size   = 2'd2;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #2;
        check("s_c0_mem_req", 64'(mem_req), 64'd0);
        exp_data_owner = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            #2;
            if (k % 2 == 0) begin
                check($sformatf("s_c%0d_mem_req", k + 1),  64'(mem_req), 64'd1);
                check($sformatf("s_c%0d_mem_addr", k + 1), 64'(mem_addr),
                      exp_data_owner ? 64'h200 : 64'h1000);
                check($sformatf("s_c%0d_d_aok", k + 1), 64'(data_addr_ok), 64'(exp_data_owner));
                check($sformatf("s_c%0d_i_aok", k + 1), 64'(inst_addr_ok), 64'(!exp_data_owner));
            end else begin
                check($sformatf("s_c%0d_mem_req", k + 1), 64'(mem_req), 64'd0);
                check($sformatf("s_c%0d_d_dok", k + 1), 64'(data_data_ok), 64'(exp_data_owner));
                check($sformatf("s_c%0d_i_dok", k + 1), 64'(inst_data_ok), 64'(!exp_data_owner));
                exp_data_owner = !exp_data_owner;
            end
        end

        // ---- store ----
        do_reset();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_wstrb = 4'hC;
        data_addr  = 32'h0000_0100;
        data_wdata = 32'hAABB_0000;
        step();
        mem_addr_ok = 1'b1;
        #2;
        check("w_c1_mem_wr",    64'(mem_wr),       64'd1);
        check("w_c1_mem_size",  64'(mem_size),     64'd2);
        check("w_c1_mem_addr",  64'(mem_addr),     64'h100);
        check("w_c1_mem_wstrb", 64'(mem_wstrb),    64'hC);
        check("w_c1_mem_wdata", 64'(mem_wdata),    64'hAABB_0000);
        check("w_c1_d_aok",     64'(data_addr_ok), 64'd1);
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #2;
        check("w_c2_d_dok", 64'(data_data_ok), 64'd1);
        check("w_c2_i_dok", 64'(inst_data_ok), 64'd0);

        // ---- locked grant: inst arrives while data waits for addr_ok ----
        do_reset();
        data_req  = 1'b1;
        data_addr = 32'h0000_0300;
        inst_addr = 32'h0000_2000;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 2) inst_req = 1'b1;
            #2;
            check($sformatf("l_c%0d_mem_req", c),  64'(mem_req),      64'd1);
            check($sformatf("l_c%0d_mem_addr", c), 64'(mem_addr),     64'h300);
            check($sformatf("l_c%0d_i_aok", c),    64'(inst_addr_ok), 64'd0);
        end
        step();
        mem_addr_ok = 1'b1;
        #2;
        check("l_c6_d_aok", 64'(data_addr_ok), 64'd1);
        check("l_c6_i_aok", 64'(inst_addr_ok), 64'd0);
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #2;
        check("l_c7_d_dok", 64'(data_data_ok), 64'd1);
        step();
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        #2;
        check("l_c8_mem_addr", 64'(mem_addr),     64'h2000);
        check("l_c8_i_aok",    64'(inst_addr_ok), 64'd1);

        // ---- reset while in RESP, then a stray data_ok ----
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_4000;
        step();
        mem_addr_ok = 1'b1;
        #2;
        check("r_c1_i_aok", 64'(inst_addr_ok), 64'd1);
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        mem_data_ok = 1'b1;
        #2;
        check_all_idle("r_c4");
        step();
        mem_data_ok = 1'b0;
        #2;
        check("r_c5_mem_req", 64'(mem_req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_mem_arbiter
